// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O block for the single-cycle core: HEX/LEDR output registers,
// debounced KEY/SW inputs and sticky KEY press flags in the 0xF00000xx/0xF00001xx page.
module mmio_ctrl #(
    parameter int               DBITS           = 32,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KEDGE      = 32'hF0000110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    output logic [DBITS-1:0] rdata,
    output logic             io_sel,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int            NIN      = 14;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]     key_s1, key_s2;
    logic [9:0]     sw_s1, sw_s2;
    logic [NIN-1:0] sync_in, db, db_next;
    logic [CW-1:0]  cnt      [NIN];
    logic [CW-1:0]  cnt_next [NIN];
    logic [15:0]    hex_reg;
    logic [3:0]     kedge, key_rise, kedge_clr;
    logic           wr_hex, wr_ledr, wr_kedge;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // Keys are inverted here so every debounced bit reads 1 when active.
    always_comb begin
        sync_in = {sw_s2, ~key_s2};
        db_next = db;
        for (int i = 0; i < NIN; i++) begin
            cnt_next[i] = '0;
            if (sync_in[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_next[i] = sync_in[i];
                end else if (cnt[i] < CNT_LAST) begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end else begin
                    cnt_next[i] = cnt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            db <= db_next;
            for (int i = 0; i < NIN; i++) cnt[i] <= cnt_next[i];
        end
    end

    assign wr_hex    = we && (addr == ADDR_HEX);
    assign wr_ledr   = we && (addr == ADDR_LEDR);
    assign wr_kedge  = we && (addr == ADDR_KEDGE);
    assign key_rise  = db_next[3:0] & ~db[3:0];
    assign kedge_clr = wr_kedge ? wdata[3:0] : 4'h0;

    // A press landing on the same edge as a W1C keeps its flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_reg <= '0;
            LEDR    <= '0;
            kedge   <= '0;
        end else begin
            if (wr_hex)  hex_reg <= wdata[15:0];
            if (wr_ledr) LEDR    <= wdata[9:0];
            kedge <= (kedge & ~kedge_clr) | key_rise;
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == ADDR_HEX)   rdata[15:0] = hex_reg;
        if (addr == ADDR_LEDR)  rdata[9:0]  = LEDR;
        if (addr == ADDR_KEY)   rdata[3:0]  = db[3:0];
        if (addr == ADDR_SW)    rdata[9:0]  = db[13:4];
        if (addr == ADDR_KEDGE) rdata[3:0]  = kedge;
    end

    assign io_sel = (addr[DBITS-1 -: 20] == 20'hF0000);
    assign HEX0   = seg7(hex_reg[3:0]);
    assign HEX1   = seg7(hex_reg[7:4]);
    assign HEX2   = seg7(hex_reg[11:8]);
    assign HEX3   = seg7(hex_reg[15:12]);

endmodule
